lisnoc_link_monitor: RTL and testbench
======================================

// Module: lisnoc_link_monitor
// PURPOSE
// - Passive, synthesisable monitor for one LISNoC virtual-channel link (flit/valid/ready).
// - Counts transferred flits and completed packets per VC and checks link protocol per VC.
// - Sits beside a link in measurement benches or on-chip debug. Never drives the link.
// PARAMETERS
// - flit_width   34  link flit width; bits [flit_width-1:flit_width-2] are the flit type
// - vchannels    4   number of virtual channels (>=1)
// - cnt_width    32  width of each per-VC counter
// PORTS
// - clk          in   1                      clock, all logic rising-edge
// - rst          in   1                      synchronous, active-high reset
// - link_flit    in   flit_width             monitored flit bus (shared by all VCs)
// - link_valid   in   vchannels              monitored per-VC valid
// - link_ready   in   vchannels              monitored per-VC ready
// - clear        in   1                      sync clear of counters and error flags
// - sel_vc       in   $clog2(vchannels) (min 1)  VC selected for readout
// - flit_count   out  cnt_width              flits transferred on sel_vc
// - packet_count out  cnt_width              packets completed on sel_vc
// - error_flags  out  4                      sticky protocol errors for sel_vc
// - error_any    out  1                      OR of all error flags over all VCs
// BEHAVIOUR
// - Transfer on VC v: link_valid[v] && link_ready[v] at a rising clk edge.
// - Flit type encoding: 2'b01 header, 2'b00 payload, 2'b10 last, 2'b11 single.
// - Per-VC FSM: IDLE -(header xfer)-> IN_PKT -(last xfer)-> IDLE. A single xfer stays in IDLE.
//   - Payload xfer stays in IN_PKT.
//   - An illegal xfer sets its error flag, and the FSM still takes the type's nominal transition.
//   - Header in IN_PKT stays in IN_PKT; payload or last in IDLE stays in IDLE.
// - Error flags, per VC, sticky:
//   - [0] more than one link_valid bit high in the same cycle. Set on every VC whose valid is high.
//   - [1] payload or last transfer while IDLE.
//   - [2] header or single transfer while IN_PKT.
//   - [3] valid withdrawn or flit changed: cycle N had valid[v]=1 and ready[v]=0, and cycle N+1
//     has valid[v]=0 or link_flit differs. Needs a registered copy of flit, valid and ready.
// - Counters: flit_count[v] +1 per transfer on v. packet_count[v] +1 per last or single transfer.
//   - Both saturate at all-ones and never wrap.
//   - Counting applies to illegal transfers as well.
// - Readout: flit_count, packet_count and error_flags are registered. They reflect the
//   selected VC's state one cycle after sel_vc is applied, i.e. 1-cycle latency.
//   - sel_vc >= vchannels reads zero.
// - error_any is registered from the current flags, so it rises 1 cycle after the flag is set.
// - clear:
//   - Zeroes all counters, error flags and the error[3] history registers.
//   - Does NOT reset the packet FSMs, so no false errors on an in-flight packet.
//   - clear has priority: a transfer in the same cycle as clear is not counted.
// - rst: all FSMs to IDLE, all counters, flags and history to 0. All outputs 0 the cycle
//   after rst. Reset mid-packet discards that packet's FSM state.
// CONFIGURATION
// - LISNOC_MONITOR_STALL_EN defined:
//   - Adds per-VC stall_count (cnt_width, saturating), +1 each cycle with valid[v]=1 and ready[v]=0.
//   - Adds output port stall_count [cnt_width-1:0], read via sel_vc with the same 1-cycle
//     latency. Cleared by clear and rst.
// - LISNOC_MONITOR_STALL_EN undefined: no stall logic, no stall_count port.
// TESTING
// - Reset, vchannels=4: hold rst 2 cycles -> all outputs 0. Sweep sel_vc 0..3 -> counts 0, flags 0.
// - Legal traffic: VC1 sends header,payload,payload,last, then VC1 single, all with ready=1
//   -> sel_vc=1 gives flit_count=5, packet_count=2, error_flags=0. VC0/2/3 stay 0.
// - Protocol errors:
//   - VC2 payload while IDLE -> error_flags[1]=1, error_any=1 a cycle later.
//   - VC3 header,header -> VC3 error_flags[2]=1.
//   - valid=4'b0011 -> error_flags[0]=1 on VC0 and VC1.
// - Withdrawal: VC0 valid=1, ready=0, flit=0x1_0000_0001; next cycle flit=0x1_0000_0002
//   -> VC0 error_flags[3]=1, flit_count unchanged.
// - Saturation and clear: cnt_width=4, 17 single xfers on VC0 -> flit_count=15, packet_count=15.
//   Then clear mid-packet (header sent), then last -> flit_count=1, packet_count=1, flags=0.
// - Stall, with LISNOC_MONITOR_STALL_EN: VC1 valid held 3 cycles with ready=0, then ready=1
//   -> stall_count=3, flit_count=1.

Source files
------------

// File: rtl/lisnoc_link_monitor.sv
// lisnoc_link_monitor
//
// Passive monitor for one LISNoC virtual-channel link. It watches the shared
// flit bus and the per-VC valid/ready pairs and never drives the link.
// For each VC it keeps:
//   - a flit counter and a packet counter. Both saturate at all-ones.
//   - a small packet FSM that tracks whether a packet is in flight.
//   - four sticky protocol error flags:
//       [0] more than one valid bit high in the same cycle
//       [1] payload or last transfer while no packet is open
//       [2] header or single transfer while a packet is open
//       [3] a stalled flit was withdrawn or changed before it was accepted
// One VC's counters and flags are shown through a registered readout mux.
//
// Optional feature: define LISNOC_MONITOR_STALL_EN to add a per-VC stall
// counter and the stall_count output port.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   link_flit    monitored flit bus; the top two bits are the flit type
//   link_valid   monitored per-VC valid
//   link_ready   monitored per-VC ready
//   clear        synchronous clear of counters, flags and withdrawal history
//   sel_vc       VC selected for readout (out-of-range VCs read zero)
//   flit_count   flits transferred on sel_vc (1-cycle latency)
//   packet_count packets completed on sel_vc (1-cycle latency)
//   error_flags  sticky error flags of sel_vc (1-cycle latency)
//   error_any    OR of every error flag of every VC, registered
//   stall_count  stall cycles on sel_vc (only with LISNOC_MONITOR_STALL_EN)

module lisnoc_link_monitor #(
  parameter int flit_width = 34,
  parameter int vchannels  = 4,
  parameter int cnt_width  = 32,
  localparam int sel_width = (vchannels > 1) ? $clog2(vchannels) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [flit_width-1:0] link_flit,
  input  logic [vchannels-1:0]  link_valid,
  input  logic [vchannels-1:0]  link_ready,
  input  logic                  clear,
  input  logic [sel_width-1:0]  sel_vc,
  output logic [cnt_width-1:0]  flit_count,
  output logic [cnt_width-1:0]  packet_count,
  output logic [3:0]            error_flags,
  output logic                  error_any
`ifdef LISNOC_MONITOR_STALL_EN
  ,
  output logic [cnt_width-1:0]  stall_count
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

  localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] TYPE_HEADER  = 2'b01;
  localparam logic [1:0] TYPE_LAST    = 2'b10;
  localparam logic [1:0] TYPE_SINGLE  = 2'b11;

  logic [1:0] flit_type;
  logic       multi_valid;

  assign flit_type = link_flit[flit_width-1 -: 2];
  // x & (x-1) clears the lowest set bit; anything left means two or more bits set.
  assign multi_valid = |(link_valid & (link_valid - vchannels'(1)));

  // Previous-cycle copy of the link used for the withdrawal check.
  logic [flit_width-1:0] flit_hist_reg;
  logic [vchannels-1:0]  valid_hist_reg;
  logic [vchannels-1:0]  ready_hist_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      flit_hist_reg  <= '0;
      valid_hist_reg <= '0;
      ready_hist_reg <= '0;
    end else begin
      flit_hist_reg  <= link_flit;
      valid_hist_reg <= link_valid;
      ready_hist_reg <= link_ready;
    end
  end

  // Per-VC state gathered for the readout mux.
  logic [cnt_width-1:0] flit_cnt_arr [vchannels];
  logic [cnt_width-1:0] pkt_cnt_arr  [vchannels];
  logic [3:0]           err_arr      [vchannels];
  logic [vchannels-1:0] err_or_vec;
`ifdef LISNOC_MONITOR_STALL_EN
  logic [cnt_width-1:0] stall_cnt_arr [vchannels];
`endif

  for (genvar gi = 0; gi < vchannels; gi++) begin : gen_vc
    pkt_state_t           state_reg, state_next;
    logic [cnt_width-1:0] flit_cnt_reg, flit_cnt_next;
    logic [cnt_width-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [3:0]           err_reg, err_next;
    logic [3:0]           err_set;
    logic                 ends_pkt;
    logic                 xfer;
    logic                 withdraw;

    assign xfer     = link_valid[gi] & link_ready[gi];
    // A stalled flit must be held unchanged until it is accepted.
    assign withdraw = valid_hist_reg[gi] & ~ready_hist_reg[gi] &
                      (~link_valid[gi] | (link_flit != flit_hist_reg));

    always_comb begin
      state_next = state_reg;
      err_set    = {withdraw, 2'b00, multi_valid & link_valid[gi]};
      ends_pkt   = 1'b0;
      // Illegal transfers flag an error but still take the nominal transition.
      if (xfer) begin
        case (flit_type)
          TYPE_HEADER: begin
            if (state_reg == IN_PKT) err_set[2] = 1'b1;
            state_next = IN_PKT;
          end
          TYPE_PAYLOAD: begin
            if (state_reg == IDLE) err_set[1] = 1'b1;
          end
          TYPE_LAST: begin
            if (state_reg == IDLE) err_set[1] = 1'b1;
            state_next = IDLE;
            ends_pkt   = 1'b1;
          end
          TYPE_SINGLE: begin
            if (state_reg == IN_PKT) err_set[2] = 1'b1;
            state_next = IDLE;
            ends_pkt   = 1'b1;
          end
          default: ;
        endcase
      end

      flit_cnt_next = flit_cnt_reg;
      pkt_cnt_next  = pkt_cnt_reg;
      err_next      = err_reg | err_set;
      // clear wins over a same-cycle transfer but leaves the FSM alone.
      if (clear) begin
        flit_cnt_next = '0;
        pkt_cnt_next  = '0;
        err_next      = '0;
      end else begin
        if (xfer && (flit_cnt_reg != '1)) flit_cnt_next = flit_cnt_reg + 1'b1;
        if (ends_pkt && (pkt_cnt_reg != '1)) pkt_cnt_next = pkt_cnt_reg + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg    <= IDLE;
        flit_cnt_reg <= '0;
        pkt_cnt_reg  <= '0;
        err_reg      <= '0;
      end else begin
        state_reg    <= state_next;
        flit_cnt_reg <= flit_cnt_next;
        pkt_cnt_reg  <= pkt_cnt_next;
        err_reg      <= err_next;
      end
    end

    assign flit_cnt_arr[gi] = flit_cnt_reg;
    assign pkt_cnt_arr[gi]  = pkt_cnt_reg;
    assign err_arr[gi]      = err_reg;
    assign err_or_vec[gi]   = |err_reg;

`ifdef LISNOC_MONITOR_STALL_EN
    logic [cnt_width-1:0] stall_cnt_reg, stall_cnt_next;

    always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (clear) begin
        stall_cnt_next = '0;
      end else if (link_valid[gi] && !link_ready[gi] && (stall_cnt_reg != '1)) begin
        stall_cnt_next = stall_cnt_reg + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) stall_cnt_reg <= '0;
      else     stall_cnt_reg <= stall_cnt_next;
    end

    assign stall_cnt_arr[gi] = stall_cnt_reg;
`else
    // Stall counting is compiled out; no per-VC stall state exists.
`endif
  end

  logic sel_ok;
  assign sel_ok = 32'(sel_vc) < 32'(vchannels);

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_count   <= '0;
      packet_count <= '0;
      error_flags  <= '0;
      error_any    <= 1'b0;
`ifdef LISNOC_MONITOR_STALL_EN
      stall_count  <= '0;
`endif
    end else begin
      flit_count   <= sel_ok ? flit_cnt_arr[sel_vc] : '0;
      packet_count <= sel_ok ? pkt_cnt_arr[sel_vc]  : '0;
      error_flags  <= sel_ok ? err_arr[sel_vc]      : '0;
      error_any    <= |err_or_vec;
`ifdef LISNOC_MONITOR_STALL_EN
      stall_count  <= sel_ok ? stall_cnt_arr[sel_vc] : '0;
`endif
    end
  end

endmodule

// File: tb/tb_lisnoc_link_monitor.sv
// Bench for lisnoc_link_monitor. Two instances share the same stimulus:
// one with 32-bit counters and one with 4-bit counters for saturation.
// A per-VC reference model (counts, open-packet bit, sticky flags, last
// cycle's link) predicts every registered output after every clock.

module tb_lisnoc_link_monitor;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  logic        clk;
  logic        rst;
  logic [33:0] link_flit;
  logic [3:0]  link_valid;
  logic [3:0]  link_ready;
  logic        clear;
  logic [1:0]  sel_vc;

  logic [31:0] fc_a, pc_a;
  logic [3:0]  ef_a;
  logic        any_a;
  logic [3:0]  fc_b, pc_b;
  logic [3:0]  ef_b;
  logic        any_b;
`ifdef LISNOC_MONITOR_STALL_EN
  logic [31:0] st_a;
  logic [3:0]  st_b;
`endif

  lisnoc_link_monitor #(.flit_width(34), .vchannels(4), .cnt_width(32)) dut (
    .clk(clk), .rst(rst), .link_flit(link_flit), .link_valid(link_valid),
    .link_ready(link_ready), .clear(clear), .sel_vc(sel_vc),
    .flit_count(fc_a), .packet_count(pc_a), .error_flags(ef_a), .error_any(any_a)
`ifdef LISNOC_MONITOR_STALL_EN
    , .stall_count(st_a)
`endif
  );

  lisnoc_link_monitor #(.flit_width(34), .vchannels(4), .cnt_width(4)) dut4 (
    .clk(clk), .rst(rst), .link_flit(link_flit), .link_valid(link_valid),
    .link_ready(link_ready), .clear(clear), .sel_vc(sel_vc),
    .flit_count(fc_b), .packet_count(pc_b), .error_flags(ef_b), .error_any(any_b)
`ifdef LISNOC_MONITOR_STALL_EN
    , .stall_count(st_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  int unsigned fc_m [4], pc_m [4], fc4_m [4], pc4_m [4], st_m [4], st4_m [4];
  logic [3:0]  ef_m [4];
  bit          open_m [4];
  logic [33:0] pf_m;
  logic [3:0]  pv_m, pr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned inc_sat(input int unsigned x, input int unsigned mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      fc_m[i] = 0; pc_m[i] = 0; fc4_m[i] = 0; pc4_m[i] = 0;
      st_m[i] = 0; st4_m[i] = 0; ef_m[i] = 4'b0; open_m[i] = 0;
    end
    pf_m = '0; pv_m = '0; pr_m = '0;
  endtask

  task automatic model_update(input logic [33:0] f, input logic [3:0] v, r, input logic c);
    int         nv;
    logic [1:0] ty;
    bit         x;
    logic [3:0] es;
    nv = $countones(v);
    ty = f[33:32];
    for (int i = 0; i < 4; i++) begin
      x  = v[i] && r[i];
      es = 4'b0;
      es[0] = (nv > 1) && v[i];
      es[3] = pv_m[i] && !pr_m[i] && (!v[i] || (f !== pf_m));
      if (x && !open_m[i] && (ty == T_PAY || ty == T_LST)) es[1] = 1'b1;
      if (x && open_m[i] && (ty == T_HDR || ty == T_SGL)) es[2] = 1'b1;
      if (c) begin
        fc_m[i] = 0; pc_m[i] = 0; fc4_m[i] = 0; pc4_m[i] = 0;
        st_m[i] = 0; st4_m[i] = 0; ef_m[i] = 4'b0;
      end else begin
        ef_m[i] = ef_m[i] | es;
        if (x) begin
          fc_m[i]  = inc_sat(fc_m[i], 32'hFFFF_FFFF);
          fc4_m[i] = inc_sat(fc4_m[i], 15);
        end
        if (x && (ty == T_LST || ty == T_SGL)) begin
          pc_m[i]  = inc_sat(pc_m[i], 32'hFFFF_FFFF);
          pc4_m[i] = inc_sat(pc4_m[i], 15);
        end
        if (v[i] && !r[i]) begin
          st_m[i]  = inc_sat(st_m[i], 32'hFFFF_FFFF);
          st4_m[i] = inc_sat(st4_m[i], 15);
        end
      end
      if (x) begin
        if (ty == T_HDR) open_m[i] = 1;
        else if (ty == T_LST || ty == T_SGL) open_m[i] = 0;
      end
    end
    if (c) begin
      pf_m = '0; pv_m = '0; pr_m = '0;
    end else begin
      pf_m = f; pv_m = v; pr_m = r;
    end
  endtask

  // One clock: drive inputs, predict outputs from the pre-edge model state
  // (readout has one cycle of latency), advance the model, then compare.
  task automatic step(input logic [33:0] f, input logic [3:0] v, r,
                      input logic c, input logic [1:0] s, input logic rs);
    int unsigned e_fc, e_pc, e_fc4, e_pc4, e_st, e_st4;
    logic [3:0]  e_ef;
    logic        e_any;
    link_flit = f; link_valid = v; link_ready = r; clear = c; sel_vc = s; rst = rs;
    @(posedge clk);
    if (rs) begin
      e_fc = 0; e_pc = 0; e_fc4 = 0; e_pc4 = 0; e_st = 0; e_st4 = 0;
      e_ef = 4'b0; e_any = 1'b0;
      model_reset();
    end else begin
      e_fc = fc_m[s]; e_pc = pc_m[s]; e_fc4 = fc4_m[s]; e_pc4 = pc4_m[s];
      e_st = st_m[s]; e_st4 = st4_m[s]; e_ef = ef_m[s];
      e_any = |{ef_m[0], ef_m[1], ef_m[2], ef_m[3]};
      model_update(f, v, r, c);
    end
    #1;
    $display("step rst=%0b clr=%0b v=%b r=%b type=%b sel=%0d fc=%0d pc=%0d ef=%b any=%0b",
             rs, c, v, r, f[33:32], s, fc_a, pc_a, ef_a, any_a);
    chk("flit_count32", 64'(fc_a), 64'(e_fc));
    chk("packet_count32", 64'(pc_a), 64'(e_pc));
    chk("error_flags32", 64'(ef_a), 64'(e_ef));
    chk("error_any32", 64'(any_a), 64'(e_any));
    chk("flit_count4", 64'(fc_b), 64'(e_fc4));
    chk("packet_count4", 64'(pc_b), 64'(e_pc4));
    chk("error_flags4", 64'(ef_b), 64'(e_ef));
    chk("error_any4", 64'(any_b), 64'(e_any));
`ifdef LISNOC_MONITOR_STALL_EN
    chk("stall_count32", 64'(st_a), 64'(e_st));
    chk("stall_count4", 64'(st_b), 64'(e_st4));
`endif
  endtask

  function automatic logic [33:0] mk(input logic [1:0] ty, input logic [31:0] d);
    return {ty, d};
  endfunction

  task automatic idle(input logic [1:0] s);
    step('0, 4'b0000, 4'b0000, 1'b0, s, 1'b0);
  endtask

  initial begin
    logic [3:0]  rv, rr;
    logic [1:0]  rs_sel;
    logic [33:0] rf;
    model_reset();
    rst = 1'b1; clear = 1'b0; link_flit = '0; link_valid = '0; link_ready = '0; sel_vc = '0;

    // Reset held two cycles, then sweep the readout.
    step('0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b1);
    step('0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b1);
    chk("rst_outputs", 64'({fc_a, pc_a, ef_a, any_a}), 64'd0);
    for (int i = 0; i < 4; i++) idle(2'(i));
    idle(2'd3);

    // Legal traffic on VC1.
    step(mk(T_HDR, 32'h11), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    step(mk(T_PAY, 32'h12), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    step(mk(T_PAY, 32'h13), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    step(mk(T_LST, 32'h14), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    step(mk(T_SGL, 32'h15), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    idle(2'd1);
    chk("legal_flit_count", 64'(fc_a), 64'd5);
    chk("legal_packet_count", 64'(pc_a), 64'd2);
    chk("legal_error_flags", 64'(ef_a), 64'd0);
    idle(2'd0); idle(2'd2); idle(2'd3);
    chk("legal_vc3_flit_count", 64'(fc_a), 64'd0);

    // VC2 payload while idle.
    step(mk(T_PAY, 32'h21), 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b0);
    idle(2'd2);
    chk("vc2_err1", 64'(ef_a[1]), 64'd1);
    chk("vc2_error_any", 64'(any_a), 64'd1);

    // VC3 header, header.
    step(mk(T_HDR, 32'h31), 4'b1000, 4'b1000, 1'b0, 2'd3, 1'b0);
    step(mk(T_HDR, 32'h32), 4'b1000, 4'b1000, 1'b0, 2'd3, 1'b0);
    idle(2'd3);
    chk("vc3_err2", 64'(ef_a[2]), 64'd1);

    // Two valids at once.
    step(mk(T_SGL, 32'h41), 4'b0011, 4'b0011, 1'b0, 2'd0, 1'b0);
    idle(2'd0);
    chk("vc0_err0", 64'(ef_a[0]), 64'd1);
    idle(2'd1);
    chk("vc1_err0", 64'(ef_a[0]), 64'd1);

    // Withdrawal: stalled flit changes.
    step('0, 4'b0, 4'b0, 1'b1, 2'd0, 1'b0);
    step(34'h1_0000_0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(34'h1_0000_0002, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle(2'd0);
    idle(2'd0);
    chk("withdraw_err3", 64'(ef_a[3]), 64'd1);
    chk("withdraw_flit_count", 64'(fc_a), 64'd0);

    // Saturation on the 4-bit instance.
    step('0, 4'b0, 4'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 17; i++)
      step(mk(T_SGL, 32'(i)), 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
    idle(2'd0);
    chk("sat_flit_count4", 64'(fc_b), 64'd15);
    chk("sat_packet_count4", 64'(pc_b), 64'd15);
    chk("nosat_flit_count32", 64'(fc_a), 64'd17);

    // Clear mid-packet: the open packet survives the clear.
    step(mk(T_HDR, 32'h51), 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
    step('0, 4'b0, 4'b0, 1'b1, 2'd0, 1'b0);
    step(mk(T_LST, 32'h52), 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
    idle(2'd0);
    chk("clr_flit_count", 64'(fc_a), 64'd1);
    chk("clr_packet_count", 64'(pc_a), 64'd1);
    chk("clr_error_flags", 64'(ef_a), 64'd0);

    // Stall on VC1: three stalled cycles then accepted.
    step('0, 4'b0, 4'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(mk(T_SGL, 32'h61), 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
    step(mk(T_SGL, 32'h61), 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0);
    idle(2'd1);
    chk("stall_flit_count", 64'(fc_a), 64'd1);
`ifdef LISNOC_MONITOR_STALL_EN
    chk("stall_count", 64'(st_a), 64'd3);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: rv = 4'b0001 << $urandom_range(0, 3);
        5:             rv = 4'b0000;
        default:       rv = 4'($urandom_range(0, 15));
      endcase
      rr     = 4'($urandom_range(0, 15));
      rf     = {2'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
      rs_sel = 2'($urandom_range(0, 3));
      step(rf, rv, rr, ($urandom_range(0, 29) == 0), rs_sel, ($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
